// File: rtl/fetch_mem_req_buffer.sv
// Fetch-side memory request buffer: forwards fetch requests, tracks in-flight
// requests with a credit counter, and queues in-order responses for the fetch stage.
module fetch_mem_req_buffer #(
  parameter int DEPTH   = 8,
  parameter int DEPTH_N = 3
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iFLUSH,
  input  logic        iFETCH_REQ,
  output logic        oFETCH_LOCK,
  input  logic [1:0]  iFETCH_MMUMOD,
  input  logic [31:0] iFETCH_ADDR,
  output logic        oINST_VALID,
  output logic        oINST_PAGEFAULT,
  output logic [13:0] oINST_MMU_FLAGS,
  output logic [31:0] oINST,
  input  logic        iINST_LOCK,
  output logic        oMEM_REQ,
  input  logic        iMEM_LOCK,
  output logic [1:0]  oMEM_MMUMOD,
  output logic [31:0] oMEM_ADDR,
  input  logic        iMEM_VALID,
  input  logic        iMEM_PAGEFAULT,
  input  logic [13:0] iMEM_MMU_FLAGS,
  input  logic [31:0] iMEM_DATA
);

  localparam logic [DEPTH_N+1:0] CAP = (DEPTH_N+2)'(DEPTH);

  logic [DEPTH_N:0]   outstanding;
  logic [DEPTH_N:0]   drop_cnt;
  logic [DEPTH_N:0]   count;
  logic [DEPTH_N-1:0] wr_ptr;
  logic [DEPTH_N-1:0] rd_ptr;
  logic [46:0]        fifo_mem [DEPTH];

  logic [DEPTH_N+1:0] used;
  logic               credit_ok;
  logic               accept;
  logic               resp;
  logic               discard;
  logic               push;
  logic               pop;

  // In-flight plus buffered entries can never exceed the FIFO size, so no overflow check.
  assign used      = {1'b0, outstanding} + {1'b0, count};
  assign credit_ok = used < CAP;

  assign oMEM_REQ    = iFETCH_REQ && credit_ok && !iFLUSH;
  assign oMEM_ADDR   = iFETCH_ADDR;
  assign oMEM_MMUMOD = iFETCH_MMUMOD;
  assign oFETCH_LOCK = iMEM_LOCK || !credit_ok;

  assign accept  = oMEM_REQ && !iMEM_LOCK;
  assign resp    = iMEM_VALID && (outstanding != '0);
  assign discard = resp && ((drop_cnt != '0) || iFLUSH);
  assign push    = resp && !discard;

  assign oINST_VALID = (count != '0) && !iINST_LOCK && !iFLUSH;
  assign pop         = oINST_VALID;
  assign {oINST_PAGEFAULT, oINST_MMU_FLAGS, oINST} = oINST_VALID ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding + {{DEPTH_N{1'b0}}, accept} - {{DEPTH_N{1'b0}}, resp};
      if (iFLUSH) begin
        // everything still in flight after this cycle's response belongs to the flushed stream
        drop_cnt <= outstanding - {{DEPTH_N{1'b0}}, resp};
        count    <= '0;
        rd_ptr   <= wr_ptr;
      end else begin
        if (resp && (drop_cnt != '0))
          drop_cnt <= drop_cnt - 1'b1;
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{DEPTH_N{1'b0}}, push} - {{DEPTH_N{1'b0}}, pop};
      end
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (push)
      fifo_mem[wr_ptr] <= {iMEM_PAGEFAULT, iMEM_MMU_FLAGS, iMEM_DATA};
  end

endmodule
